// File: rtl/subtractor_seq.sv
// Sequential 32-bit subtractor: CHUNK bits per cycle, LSB chunk first, borrow rippled across cycles.
// Define SUBTRACTOR_SEQ_SAT_EN to saturate diff on signed overflow; otherwise diff is the wrapped result.
module subtractor_seq #(
  parameter int CHUNK = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] diff,
  output logic        bout,
  output logic        overf
);

  localparam int N  = 32 / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            borrow_q, borrow_d;
  logic [31:0]     a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic            done_q, done_d;
  logic [31:0]     diff_q, diff_d;
  logic            bout_q, bout_d;
  logic            overf_q, overf_d;

  logic [5:0]        base;
  logic [CHUNK-1:0]  a_ch, b_ch;
  logic [CHUNK:0]    sub;
  logic [31:0]       full;
  logic              ovf;

  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

`ifdef SUBTRACTOR_SEQ_SAT_EN
  // On overflow the result sign is opposite to a's sign, so clamp toward a's sign.
  function automatic logic [31:0] sat32(input logic signed [31:0] wrapped, input logic of);
    if (!of)
      return wrapped;
    return wrapped[31] ? 32'h7FFF_FFFF : 32'h8000_0000;
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    bout_d   = bout_q;
    overf_d  = overf_q;

    base = 6'(cnt_q) * 6'(CHUNK);
    a_ch = a_q[base +: CHUNK];
    b_ch = b_q[base +: CHUNK];
    // Top bit of the widened difference is the borrow out of this chunk.
    sub  = {1'b0, a_ch} - {1'b0, b_ch} - {{CHUNK{1'b0}}, borrow_q};
    full = acc_q;
    full[base +: CHUNK] = sub[CHUNK-1:0];
    ovf  = sub_ovf(a_q[31], b_q[31], full[31]);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = full;
        borrow_d = sub[CHUNK];
        if (cnt_q == CW'(N - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          bout_d  = sub[CHUNK];
          overf_d = ovf;
`ifdef SUBTRACTOR_SEQ_SAT_EN
          diff_d  = sat32(full, ovf);
`else
          diff_d  = full;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      overf_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      overf_q  <= overf_d;
    end
  end

  // Operand and partial-result registers carry no reset; they are reloaded on every accepted start.
  always_ff @(posedge clock) begin
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
  end

  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign diff  = diff_q;
  assign bout  = bout_q;
  assign overf = overf_q;

endmodule

// File: tb/tb_subtractor_seq.sv
// Scoreboard bench for subtractor_seq: three instances (CHUNK=8, 1, 32) driven in turn with directed vectors.
module tb_subtractor_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_s [3];
  logic [31:0] a_s [3];
  logic [31:0] b_s [3];
  logic        busy_s [3];
  logic        done_s [3];
  logic [31:0] diff_s [3];
  logic        bout_s [3];
  logic        overf_s [3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          k;
    logic [31:0] d;
    logic        bo;
    logic        ov;
    int          at;
  } exp_t;
  exp_t sb[$];

  localparam int LAT [3] = '{4, 32, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CH = (g == 0) ? 8 : ((g == 1) ? 1 : 32);
    subtractor_seq #(.CHUNK(CH)) u_dut (
      .clock(clk), .reset(rst), .start(start_s[g]), .a(a_s[g]), .b(b_s[g]),
      .busy(busy_s[g]), .done(done_s[g]), .diff(diff_s[g]), .bout(bout_s[g]), .overf(overf_s[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest scoreboard entry, including its arrival cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_s[k] === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done inst=%0d cycle=%0d: got done=1 expected none", k, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("inst%0d_tag", k), k, e.k);
          chk($sformatf("inst%0d_diff", k), diff_s[k], e.d);
          chk($sformatf("inst%0d_bout", k), {31'b0, bout_s[k]}, {31'b0, e.bo});
          chk($sformatf("inst%0d_overf", k), {31'b0, overf_s[k]}, {31'b0, e.ov});
          chk($sformatf("inst%0d_latency_cycle", k), cyc, e.at);
        end
      end
    end
  end

  // Called on a negedge: drives start for one edge and pushes the expected result.
  task automatic launch(input int k, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ed, input logic eb, input logic eo, input bit push);
    exp_t e;
    start_s[k] = 1'b1;
    a_s[k] = av;
    b_s[k] = bv;
    if (push) begin
      e.k = k; e.d = ed; e.bo = eb; e.ov = eo; e.at = cyc + 1 + LAT[k];
      sb.push_back(e);
    end
    @(negedge clk);
    start_s[k] = 1'b0;
    a_s[k] = $urandom;
    b_s[k] = $urandom;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (busy_s[k] === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy_s[k] === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL timeout inst=%0d: got busy=1 expected done within 40 cycles", k);
    end
  endtask

  task automatic run_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ed, input logic eb, input logic eo);
    launch(k, av, bv, ed, eb, eo, 1'b1);
    wait_idle(k);
    @(negedge clk);
  endtask

  logic [31:0] sat_neg, sat_pos;

  initial begin
`ifdef SUBTRACTOR_SEQ_SAT_EN
    sat_neg = 32'h8000_0000;
    sat_pos = 32'h7FFF_FFFF;
`else
    sat_neg = 32'h7FFF_FFFF;
    sat_pos = 32'h8000_0000;
`endif
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; a_s[k] = '0; b_s[k] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_busy%0d", k), {31'b0, busy_s[k]}, 32'd0);
      chk($sformatf("rst_done%0d", k), {31'b0, done_s[k]}, 32'd0);
      chk($sformatf("rst_diff%0d", k), diff_s[k], 32'd0);
      chk($sformatf("rst_flags%0d", k), {30'b0, bout_s[k], overf_s[k]}, 32'd0);
    end

    for (int k = 0; k < 3; k++) begin
      run_op(k, 32'd5, 32'd3, 32'h0000_0002, 1'b0, 1'b0);
      run_op(k, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0);
      run_op(k, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0);
      run_op(k, 32'h8000_0000, 32'h0000_0001, sat_neg, 1'b0, 1'b1);
      run_op(k, 32'h7FFF_FFFF, 32'hFFFF_FFFF, sat_pos, 1'b1, 1'b1);
      run_op(k, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
    end

    // Handshake on the CHUNK=8 instance: start while busy is ignored, start in done cycle is taken.
    launch(0, 32'd10, 32'd4, 32'd6, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    launch(0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("hold_diff_during_run", diff_s[0], 32'h0000_0000);
    chk("busy_in_run", {31'b0, busy_s[0]}, 32'd1);
    wait_idle(0);
    chk("done_cycle_busy_low", {31'b0, done_s[0]}, 32'd1);
    launch(0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("busy_after_back_to_back", {31'b0, busy_s[0]}, 32'd1);
    chk("hold_diff_second_run", diff_s[0], 32'd6);
    wait_idle(0);
    @(negedge clk);

    // Leave a nonzero result so the reset clearing is visible.
    run_op(0, 32'd7, 32'd9, 32'hFFFF_FFFE, 1'b1, 1'b0);
    launch(0, 32'd9, 32'd2, 32'd7, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'b0, busy_s[0]}, 32'd0);
    chk("abort_done", {31'b0, done_s[0]}, 32'd0);
    chk("abort_diff", diff_s[0], 32'd0);
    chk("abort_flags", {30'b0, bout_s[0], overf_s[0]}, 32'd0);
    repeat (8) @(negedge clk);
    chk("abort_diff_later", diff_s[0], 32'd0);

    run_op(0, 32'd5, 32'd3, 32'h0000_0002, 1'b0, 1'b0);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
